// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: requester tags, the
// read/write encoding of the SRAM port and the default bus widths.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_DISP  = 2'd1,
    REQ_TOUCH = 2'd2,
    REQ_COMP  = 2'd3
  } req_tag_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-driver signal bundle around the arbiter.
// Handshake: a requester holds req high with stable rw/addr/wdata until the
// cycle in which gnt pulses; that cycle consumes the request, and req may drop
// or change from the next cycle on. Reads return later as a one-cycle rvalid
// pulse qualifying the shared rdata.
interface sram_arbiter_if import sram_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              i_req_disp, i_req_touch, i_req_comp;
  logic              i_rw_disp, i_rw_touch, i_rw_comp;
  logic [ADDR_W-1:0] i_addr_disp, i_addr_touch, i_addr_comp;
  logic [DATA_W-1:0] i_wdata_touch, i_wdata_comp;
  logic              o_gnt_disp, o_gnt_touch, o_gnt_comp;
  logic              o_rvalid_disp, o_rvalid_touch, o_rvalid_comp;
  logic [DATA_W-1:0] o_rdata;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_sram_dout;
  logic              o_sram_rw;
  logic [DATA_W-1:0] i_sram_rdata;

  modport slave (
    input  i_req_disp, i_req_touch, i_req_comp,
    input  i_rw_disp, i_rw_touch, i_rw_comp,
    input  i_addr_disp, i_addr_touch, i_addr_comp,
    input  i_wdata_touch, i_wdata_comp, i_sram_rdata,
    output o_gnt_disp, o_gnt_touch, o_gnt_comp,
    output o_rvalid_disp, o_rvalid_touch, o_rvalid_comp,
    output o_rdata, o_sram_addr, o_sram_dout, o_sram_rw
  );

  modport master (
    output i_req_disp, i_req_touch, i_req_comp,
    output i_rw_disp, i_rw_touch, i_rw_comp,
    output i_addr_disp, i_addr_touch, i_addr_comp,
    output i_wdata_touch, i_wdata_comp, i_sram_rdata,
    input  o_gnt_disp, o_gnt_touch, o_gnt_comp,
    input  o_rvalid_disp, o_rvalid_touch, o_rvalid_comp,
    input  o_rdata, o_sram_addr, o_sram_dout, o_sram_rw
  );

endinterface

// File: rtl/sram_rd_tag_pipe.sv
// Shift register carrying the owner tag of each issued access so that read
// data coming back from the SRAM can be steered to the requester that asked.
module sram_rd_tag_pipe import sram_arb_pkg::*; #(
  parameter int DEPTH = 3
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  req_tag_e i_tag,
  output req_tag_e o_tag
);

  req_tag_e stages [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= REQ_NONE;
    end else begin
      stages[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign o_tag = stages[DEPTH-1];

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates display, touch and compare requesters onto one SRAM port:
// display first unless a low-priority requester has been starved too long.
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 15
) (
  input logic           i_clk,
  input logic           i_rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic              rrComp;      // round-robin pointer: 0 favours touch
  logic [7:0]        starveCnt;
  logic              loAny, loTouch, loComp, starveHit;
  logic              gntDisp, gntTouch, gntComp;
  logic [ADDR_W-1:0] sramAddr;
  logic [DATA_W-1:0] sramDout;
  logic              sramRw;
  req_tag_e          pushTag, tailTag;

  always_comb begin
    loAny     = bus.i_req_touch | bus.i_req_comp;
    loTouch   = bus.i_req_touch & (~bus.i_req_comp | ~rrComp);
    loComp    = bus.i_req_comp & ~loTouch;
    starveHit = (starveCnt == STARVE_LIM) & loAny;
    gntDisp   = i_rst_n & bus.i_req_disp & ~starveHit;
    gntTouch  = i_rst_n & ~gntDisp & loTouch;
    gntComp   = i_rst_n & ~gntDisp & loComp;
    pushTag   = REQ_NONE;
    if (gntDisp)                                      pushTag = REQ_DISP;
    else if (gntTouch && bus.i_rw_touch == RW_READ) pushTag = REQ_TOUCH;
    else if (gntComp && bus.i_rw_comp == RW_READ)   pushTag = REQ_COMP;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rrComp    <= 1'b0;
      starveCnt <= '0;
      sramAddr  <= '0;
      sramDout  <= '0;
      sramRw    <= RW_READ;
    end else begin
      if (gntTouch)     rrComp <= 1'b1;
      else if (gntComp) rrComp <= 1'b0;

      if (gntTouch || gntComp || !loAny)
        starveCnt <= '0;
      else if (gntDisp && starveCnt != STARVE_LIM)
        starveCnt <= starveCnt + 8'd1;

      // Idle cycles park the port in read so the driver never sees a stray write.
      sramRw <= RW_READ;
      if (gntDisp) begin
        sramAddr <= bus.i_addr_disp;
      end else if (gntTouch) begin
        sramAddr <= bus.i_addr_touch;
        sramDout <= bus.i_wdata_touch;
        sramRw   <= bus.i_rw_touch;
      end else if (gntComp) begin
        sramAddr <= bus.i_addr_comp;
        sramDout <= bus.i_wdata_comp;
        sramRw   <= bus.i_rw_comp;
      end
    end
  end

  sram_rd_tag_pipe #(.DEPTH(READ_LAT + 1)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tag   (pushTag),
    .o_tag   (tailTag)
  );

  assign bus.o_gnt_disp     = gntDisp;
  assign bus.o_gnt_touch    = gntTouch;
  assign bus.o_gnt_comp     = gntComp;
  assign bus.o_rvalid_disp  = i_rst_n & (tailTag == REQ_DISP);
  assign bus.o_rvalid_touch = i_rst_n & (tailTag == REQ_TOUCH);
  assign bus.o_rvalid_comp  = i_rst_n & (tailTag == REQ_COMP);
  assign bus.o_rdata        = (i_rst_n && tailTag != REQ_NONE) ? bus.i_sram_rdata : '0;
  assign bus.o_sram_addr    = sramAddr;
  assign bus.o_sram_dout    = sramDout;
  assign bus.o_sram_rw      = sramRw;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized bench for sram_arbiter with an SRAM driver model and
// a transaction-level reference for grants, port contents and read returns.
module tb_sram_arbiter;

  localparam int READ_LAT   = 2;
  localparam int STARVE_MAX = 15;
  localparam int T_NONE = 0, T_DISP = 1, T_TOUCH = 2, T_COMP = 3;

  logic iCLK_50 = 1'b0;
  logic rstN    = 1'b0;
  always #5 iCLK_50 = ~iCLK_50;

  sram_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  sram_arbiter #(.ADDR_W(19), .DATA_W(8), .READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk   (iCLK_50),
    .i_rst_n (rstN),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // requester shadow state, index 0 = disp, 1 = touch, 2 = comp
  bit          rq [3];
  bit          rw [3];
  logic [18:0] ad [3];
  logic [7:0]  wd [3];

  logic [7:0]  refMem  [int];
  logic [7:0]  sramMem [int];
  logic [7:0]  rdSched [int];
  int          retWho  [int];
  logic [7:0]  retData [int];

  int          cyc = 0;
  bit          ptrComp = 0;
  int          starve = 0;
  bit          portKnown = 0;
  bit          doutKnown = 0;
  logic [18:0] expAddr = '0;
  logic [7:0]  expDout = '0;
  logic        expRw = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    refMem[a]  = d;
    sramMem[a] = d;
  endtask

  function automatic logic [7:0] mem_rd(input int a);
    return refMem.exists(a) ? refMem[a] : 8'h00;
  endfunction

  // One clock cycle: drive inputs, model the SRAM driver, check, advance the reference.
  task automatic step(input bit rst, output int eg, output int og);
    int lo, ew, a, idx;
    bit isRead;
    @(negedge iCLK_50);
    rstN              = rst;
    bus.i_req_disp    = rq[0];  bus.i_req_touch  = rq[1];  bus.i_req_comp  = rq[2];
    bus.i_rw_disp     = rw[0];  bus.i_rw_touch   = rw[1];  bus.i_rw_comp   = rw[2];
    bus.i_addr_disp   = ad[0];  bus.i_addr_touch = ad[1];  bus.i_addr_comp = ad[2];
    bus.i_wdata_touch = wd[1];  bus.i_wdata_comp = wd[2];
    if (bus.o_sram_rw === 1'b0) begin
      sramMem[int'(bus.o_sram_addr)] = bus.o_sram_dout;
    end else if (bus.o_sram_rw === 1'b1) begin
      a = int'(bus.o_sram_addr);
      rdSched[cyc + READ_LAT] = sramMem.exists(a) ? sramMem[a] : 8'h00;
    end
    if (rdSched.exists(cyc)) begin
      bus.i_sram_rdata = rdSched[cyc];
      rdSched.delete(cyc);
    end else begin
      bus.i_sram_rdata = 8'($urandom);
    end
    #1;

    lo = T_NONE;
    if (rq[1] && rq[2]) lo = ptrComp ? T_COMP : T_TOUCH;
    else if (rq[1])     lo = T_TOUCH;
    else if (rq[2])     lo = T_COMP;
    if (!rst)                                   eg = T_NONE;
    else if (starve == STARVE_MAX && lo != T_NONE) eg = lo;
    else if (rq[0])                             eg = T_DISP;
    else                                        eg = lo;

    og = bus.o_gnt_disp ? T_DISP : bus.o_gnt_touch ? T_TOUCH : bus.o_gnt_comp ? T_COMP : T_NONE;
    chk("gnt_disp",  bus.o_gnt_disp,  eg == T_DISP);
    chk("gnt_touch", bus.o_gnt_touch, eg == T_TOUCH);
    chk("gnt_comp",  bus.o_gnt_comp,  eg == T_COMP);

    if (portKnown) begin
      chk("sram_rw",   bus.o_sram_rw,   expRw);
      chk("sram_addr", bus.o_sram_addr, expAddr);
      if (doutKnown) chk("sram_dout", bus.o_sram_dout, expDout);
    end

    ew = (rst && retWho.exists(cyc)) ? retWho[cyc] : T_NONE;
    chk("rvalid_disp",  bus.o_rvalid_disp,  ew == T_DISP);
    chk("rvalid_touch", bus.o_rvalid_touch, ew == T_TOUCH);
    chk("rvalid_comp",  bus.o_rvalid_comp,  ew == T_COMP);
    if (ew != T_NONE) chk("rdata", bus.o_rdata, retData[cyc]);
    else if (!rst)    chk("rdata_rst", bus.o_rdata, 8'h00);
    if (retWho.exists(cyc)) begin
      retWho.delete(cyc);
      retData.delete(cyc);
    end

    if (!rst) begin
      ptrComp = 0;  starve = 0;
      portKnown = 1;  doutKnown = 1;
      expAddr = '0;  expDout = '0;  expRw = 1'b1;
      retWho.delete();
      retData.delete();
    end else begin
      if (eg == T_TOUCH)     ptrComp = 1;
      else if (eg == T_COMP) ptrComp = 0;
      if (eg == T_TOUCH || eg == T_COMP || !(rq[1] || rq[2])) starve = 0;
      else if (eg == T_DISP && starve < STARVE_MAX)           starve++;
      expRw = 1'b1;
      if (eg != T_NONE) begin
        idx     = eg - 1;
        isRead  = (eg == T_DISP) || rw[idx];
        expAddr = ad[idx];
        expRw   = isRead;
        if (isRead) begin
          doutKnown = 0;
          retWho[cyc + 1 + READ_LAT]  = eg;
          retData[cyc + 1 + READ_LAT] = mem_rd(int'(ad[idx]));
        end else begin
          doutKnown = 1;
          expDout   = wd[idx];
          refMem[int'(ad[idx])] = wd[idx];
        end
      end
    end
    cyc++;
  endtask

  task automatic set_req(input int k, input bit r, input bit w, input int a, input logic [7:0] d);
    rq[k] = r;  rw[k] = w;  ad[k] = 19'(a);  wd[k] = d;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < 3; k++) rq[k] = 0;
  endtask

  initial begin
    int eg, og, touchCnt, run, maxRun;
    bit rstBit;
    bus.i_sram_rdata = 8'h00;
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b1, 'h10 + k, 8'h00);
    preload('h00123, 8'h5A);
    preload('h00200, 8'hA1);
    preload('h00201, 8'hB2);
    preload('h00203, 8'hD4);
    preload('h00300, 8'h3C);

    // reset held with every requester asserted, then release: display wins first
    for (int n = 0; n < 3; n++) step(1'b0, eg, og);
    step(1'b1, eg, og);
    clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // single compare read of a preloaded word
    set_req(2, 1'b1, 1'b1, 'h00123, 8'h00);
    step(1'b1, eg, og);
    clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // touch and compare writes held together: strict alternation
    set_req(1, 1'b1, 1'b0, 'h00050, 8'h11);
    set_req(2, 1'b1, 1'b0, 'h00060, 8'h22);
    for (int n = 0; n < 8; n++) begin
      step(1'b1, eg, og);
      if (eg == T_TOUCH) begin ad[1] = ad[1] + 19'd1; wd[1] = wd[1] + 8'd1; end
      if (eg == T_COMP)  begin ad[2] = ad[2] + 19'd1; wd[2] = wd[2] + 8'd3; end
    end
    clear_reqs();
    step(1'b1, eg, og);

    // display saturating the port while touch keeps asking
    set_req(0, 1'b1, 1'b1, 'h00000, 8'h00);
    set_req(1, 1'b1, 1'b0, 'h00070, 8'h40);
    touchCnt = 0;  run = 0;  maxRun = 0;
    for (int n = 0; n < 48; n++) begin
      step(1'b1, eg, og);
      if (og == T_TOUCH) touchCnt++;
      if (og != T_DISP) run++; else run = 0;
      if (run > maxRun) maxRun = run;
      ad[0] = ad[0] + 19'd1;
    end
    chk("starve_touch_grants", touchCnt, 3);
    chk("disp_max_denied_run", maxRun, 1);
    clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // ordered return: disp read, comp read, touch write, disp read
    set_req(0, 1'b1, 1'b0, 'h00200, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    set_req(2, 1'b1, 1'b1, 'h00201, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    set_req(1, 1'b1, 1'b0, 'h00202, 8'hC3);  step(1'b1, eg, og);  clear_reqs();
    set_req(0, 1'b1, 1'b1, 'h00203, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // write then read of the same address on consecutive grants
    set_req(1, 1'b1, 1'b0, 'h00300, 8'h99);  step(1'b1, eg, og);
    set_req(1, 1'b1, 1'b1, 'h00300, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // reset one cycle after a read grant drops that read
    set_req(2, 1'b1, 1'b1, 'h00123, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    step(1'b0, eg, og);
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);
    set_req(2, 1'b1, 1'b1, 'h00123, 8'h00);  step(1'b1, eg, og);  clear_reqs();
    for (int n = 0; n < 4; n++) step(1'b1, eg, og);

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (!rq[k] && $urandom_range(0, 2) == 0)
          set_req(k, 1'b1, 1'($urandom_range(0, 1)), 'h40 + $urandom_range(0, 7), 8'($urandom));
      end
      rstBit = ($urandom_range(0, 99) != 0);
      step(rstBit, eg, og);
      if (eg != T_NONE) rq[eg - 1] = 0;
    end
    clear_reqs();
    for (int n = 0; n < 5; n++) step(1'b1, eg, og);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port among the three requesters: LCD display fetch, touch-stroke writer and stroke comparator. Issues at most one access per cycle, gives display fixed top priority with a starvation guard, alternates round-robin between touch and compare, and routes returning read data to the requester that issued the read. Sits between those requesters and the SRAM driver, replacing ad-hoc address muxing in the top-level control.

## Interface
- ADDR_W, 19: SRAM address width.
- DATA_W, 8: data width.
- READ_LAT, 2: cycles from SRAM port drive to valid `i_sram_rdata`; 1..4.
- STARVE_MAX, 15: consecutive display grants tolerated while a low-priority request waits; 1..255.

Ports; x in {disp, touch, comp}:
- i_clk  in  1  system clock (12.5 MHz domain).
- i_rst_n  in  1  synchronous active-low reset.
- i_req_x  in  1  request; held with fields stable until granted.
- i_rw_x  in  1  1 = read, 0 = write (`i_rw_disp` is ignored; display always reads).
- i_addr_x  in  ADDR_W  access address.
- i_wdata_x  in  DATA_W  write data (touch and compare only).
- o_gnt_x  out  1  one-cycle grant pulse.
- o_rvalid_x  out  1  one-cycle read-data-valid pulse.
- o_rdata  out  DATA_W  read data, shared; qualified by `o_rvalid_x`.
- o_sram_addr  out  ADDR_W  to SRAM driver.
- o_sram_dout  out  DATA_W  write data to SRAM driver.
- o_sram_rw  out  1  1 = read, 0 = write.
- i_sram_rdata  in  DATA_W  read data from SRAM driver.

## Operation
- Grants are combinational from requests, pointer and starvation counter. At most one `o_gnt_*` is high per cycle. The granted request is consumed in that cycle; the requester may drop or change `req` next cycle.
- Priority:
  - If the starvation counter equals STARVE_MAX and touch or compare is requesting, the low-priority winner is granted.
  - Else display is granted if it is requesting.
  - Else the low-priority winner is granted.
- Low-priority winner: the round-robin pointer selects touch or compare. If only one is requesting, that one wins. After a touch or compare grant, the pointer moves to the other requester.
- Starvation counter:
  - Increments on a display grant while touch or compare is requesting.
  - Clears on any touch or compare grant, or when neither is requesting.
  - Saturates at STARVE_MAX.
- Port: the granted access is registered onto `o_sram_*` at the end of the grant cycle. With no grant, the port idles with `o_sram_rw`=1 and addr/dout holding their last value, so no spurious write.
- Read return: each read grant pushes a requester tag into a depth-(READ_LAT+1) tag pipeline. When the tag reaches the tail, `o_rdata`=`i_sram_rdata` and the matching `o_rvalid_x` pulses. Writes push tag NONE and produce no rvalid.
- Back-to-back reads from different requesters return in issue order, one per cycle.
- Reset (at any time, including mid-read):
  - Tag pipeline cleared, so in-flight reads produce no rvalid.
  - Pointer resets to touch; counter = 0.
  - All `o_gnt_*`/`o_rvalid_*` = 0, `o_rdata` = 0, `o_sram_addr` = 0, `o_sram_dout` = 0, `o_sram_rw` = 1.

## Timing
- Grant at cycle t if the request is high in cycle t and it wins arbitration.
- Access is on the SRAM port during t+1.
- Read data `o_rvalid_x`/`o_rdata` appear in cycle t+1+READ_LAT; throughput is 1 access/cycle.
- A request asserted in the same cycle as reset deassertion is arbitrated in the first post-reset cycle.
- A write granted at t and a read of the same address granted at t+1 returns the new data; the SRAM driver guarantees write-then-read order.

## Structure
- Package `sram_arb_pkg`:
  - Requester tag enum REQ_NONE/REQ_DISP/REQ_TOUCH/REQ_COMP (2 bits).
  - RW_READ=1 and RW_WRITE=0 constants.
  - Default ADDR_W/DATA_W.
- Sub-module `sram_rd_tag_pipe`: parameterised shift register of tags with synchronous clear, output tag at depth READ_LAT+1.
- Top module holds the arbitration logic, pointer, starvation counter and port registers.

## Test plan
- Reset: hold `i_rst_n`=0 with all reqs high → no grants, `o_sram_rw`=1, addr 0. Release → display granted first cycle.
- Single read: comp reads addr 0x00123 at t; SRAM model returns 0x5A → `o_gnt_comp` at t, port addr 0x00123 rw=1 at t+1, `o_rvalid_comp`=1 with `o_rdata`=0x5A at t+3 (READ_LAT=2).
- Round-robin: touch and comp writes both held continuously, display idle → grants alternate touch, comp, touch, comp; `o_sram_rw`=0 each following cycle.
- Starvation: display held continuously, touch request pending → exactly one touch grant after every 15 display grants (STARVE_MAX=15); display never denied more than one cycle in a row.
- Ordered return: disp read A, comp read B, touch write C, disp read D on consecutive cycles → rvalid sequence disp, comp, (none), disp with matching data on consecutive cycles.
- Reset mid-read: assert reset one cycle after a read grant → no rvalid for that read; next post-reset read returns correctly.
